// File: rtl/aud_session_ctrl.sv
// Session sequencer for the audio record/playback path.
// Turns debounced key pulses into registered one-cycle recorder/player
// commands, owns the recorded length, the playback address counter with
// fast (skip) / slow (repeat) speed stepping, and the SRAM owner select.
module aud_session_ctrl #(
  parameter int ADDR_W    = 20,
  parameter int MAX_SPEED = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,      // active-high synchronous reset
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic [3:0]        i_speed,
  input  logic              i_fast,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic              i_rec_full,
  input  logic              i_play_next,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_play_start,
  output logic              o_play_pause,
  output logic              o_play_stop,
  output logic [ADDR_W-1:0] o_play_addr,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_sram_sel,
  output logic [2:0]        o_state
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_REC        = 3'd1;
  localparam logic [2:0] ST_REC_PAUSE  = 3'd2;
  localparam logic [2:0] ST_PLAY       = 3'd3;
  localparam logic [2:0] ST_PLAY_PAUSE = 3'd4;

  localparam logic [3:0] SPEED_MAX = 4'(MAX_SPEED);

  // Registered state
  logic [2:0]        state_reg,      state_next;
  logic [ADDR_W-1:0] play_addr_reg,  play_addr_next;
  logic [ADDR_W-1:0] end_addr_reg,   end_addr_next;
  logic [3:0]        rpt_cnt_reg,    rpt_cnt_next;
  logic              sram_sel_reg,   sram_sel_next;

  // Command pulses: {rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop}
  logic [5:0]        cmd_reg,        cmd_next;

  // Address stepping helpers
  logic [3:0]        speed_eff;
  logic [ADDR_W:0]   step_amt;
  logic [ADDR_W:0]   step_addr;
  logic              past_end;
  logic              slow_wrap;

  // Clamp the requested speed into 1..MAX_SPEED
  always_comb begin
    speed_eff = i_speed;
    if (i_speed == 4'd0) begin
      speed_eff = 4'd1;
    end else if (i_speed > SPEED_MAX) begin
      speed_eff = SPEED_MAX;
    end
  end

  // One extra bit so a step beyond the top of SRAM is still seen as past the end
  assign step_amt  = i_fast ? {{(ADDR_W-3){1'b0}}, speed_eff} : {{ADDR_W{1'b0}}, 1'b1};
  assign step_addr = {1'b0, play_addr_reg} + step_amt;
  assign past_end  = step_addr > {1'b0, end_addr_reg};
  // >= keeps the repeat counter sane if the speed is lowered mid-playback
  assign slow_wrap = rpt_cnt_reg >= (speed_eff - 4'd1);

  // Next-state, command and datapath decode
  always_comb begin
    state_next     = state_reg;
    play_addr_next = play_addr_reg;
    end_addr_next  = end_addr_reg;
    rpt_cnt_next   = rpt_cnt_reg;
    cmd_next       = 6'b000000;

    case (state_reg)
      ST_IDLE: begin
        // Pause/stop have nothing to act on here; rec wins over play.
        if (i_key_rec) begin
          state_next    = ST_REC;
          cmd_next[5]   = 1'b1;
          end_addr_next = '0;
        end else if (i_key_play && (end_addr_reg != '0)) begin
          state_next     = ST_PLAY;
          cmd_next[2]    = 1'b1;
          play_addr_next = '0;
          rpt_cnt_next   = 4'd0;
        end
      end

      ST_REC: begin
        // Length follows the recorder, including the edge that stops it.
        end_addr_next = i_rec_addr;
        if (i_key_stop || i_rec_full) begin
          state_next  = ST_IDLE;
          cmd_next[3] = 1'b1;
        end else if (i_key_pause) begin
          state_next  = ST_REC_PAUSE;
          cmd_next[4] = 1'b1;
        end
      end

      ST_REC_PAUSE: begin
        if (i_key_stop) begin
          state_next  = ST_IDLE;
          cmd_next[3] = 1'b1;
        end else if (i_key_pause) begin
          state_next  = ST_REC_PAUSE;
        end else if (i_key_rec) begin
          // Resume appends: the recorded length is kept.
          state_next  = ST_REC;
          cmd_next[5] = 1'b1;
        end
      end

      ST_PLAY: begin
        if (i_key_stop) begin
          state_next  = ST_IDLE;
          cmd_next[0] = 1'b1;
        end else if (i_key_pause) begin
          state_next  = ST_PLAY_PAUSE;
          cmd_next[1] = 1'b1;
        end else if (i_play_next) begin
          if (i_fast || slow_wrap) begin
            if (past_end) begin
              // End of recording: address holds at the last valid sample.
              state_next  = ST_IDLE;
              cmd_next[0] = 1'b1;
            end else begin
              play_addr_next = step_addr[ADDR_W-1:0];
              rpt_cnt_next   = 4'd0;
            end
          end else begin
            rpt_cnt_next = rpt_cnt_reg + 4'd1;
          end
        end
      end

      ST_PLAY_PAUSE: begin
        if (i_key_stop) begin
          state_next  = ST_IDLE;
          cmd_next[0] = 1'b1;
        end else if (i_key_pause) begin
          state_next  = ST_PLAY_PAUSE;
        end else if (i_key_play) begin
          state_next  = ST_PLAY;
          cmd_next[2] = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Player owns SRAM whenever a playback session is open
  always_comb begin
    sram_sel_next = (state_next == ST_PLAY) || (state_next == ST_PLAY_PAUSE);
  end

  // State and datapath registers; reset drops any session without a stop pulse
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state_reg     <= ST_IDLE;
      play_addr_reg <= '0;
      end_addr_reg  <= '0;
      rpt_cnt_reg   <= 4'd0;
      sram_sel_reg  <= 1'b0;
      cmd_reg       <= 6'b000000;
    end else begin
      state_reg     <= state_next;
      play_addr_reg <= play_addr_next;
      end_addr_reg  <= end_addr_next;
      rpt_cnt_reg   <= rpt_cnt_next;
      sram_sel_reg  <= sram_sel_next;
      cmd_reg       <= cmd_next;
    end
  end

  assign o_rec_start  = cmd_reg[5];
  assign o_rec_pause  = cmd_reg[4];
  assign o_rec_stop   = cmd_reg[3];
  assign o_play_start = cmd_reg[2];
  assign o_play_pause = cmd_reg[1];
  assign o_play_stop  = cmd_reg[0];
  assign o_play_addr  = play_addr_reg;
  assign o_end_addr   = end_addr_reg;
  assign o_sram_sel   = sram_sel_reg;
  assign o_state      = state_reg;

endmodule

// File: tb/tb_aud_session_ctrl.sv
// Directed bench for aud_session_ctrl: record, play (fast/slow), pause,
// stop, end-of-recording, SRAM full and mid-session reset.
module tb_aud_session_ctrl;

  localparam int ADDR_W = 20;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_key_rec, i_key_play, i_key_pause, i_key_stop;
  logic [3:0]        i_speed;
  logic              i_fast;
  logic [ADDR_W-1:0] i_rec_addr;
  logic              i_rec_full;
  logic              i_play_next;
  logic              o_rec_start, o_rec_pause, o_rec_stop;
  logic              o_play_start, o_play_pause, o_play_stop;
  logic [ADDR_W-1:0] o_play_addr;
  logic [ADDR_W-1:0] o_end_addr;
  logic              o_sram_sel;
  logic [2:0]        o_state;

  int n_checks = 0;
  int n_fail   = 0;

  aud_session_ctrl #(.ADDR_W(ADDR_W), .MAX_SPEED(8)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_key_rec    (i_key_rec),
    .i_key_play   (i_key_play),
    .i_key_pause  (i_key_pause),
    .i_key_stop   (i_key_stop),
    .i_speed      (i_speed),
    .i_fast       (i_fast),
    .i_rec_addr   (i_rec_addr),
    .i_rec_full   (i_rec_full),
    .i_play_next  (i_play_next),
    .o_rec_start  (o_rec_start),
    .o_rec_pause  (o_rec_pause),
    .o_rec_stop   (o_rec_stop),
    .o_play_start (o_play_start),
    .o_play_pause (o_play_pause),
    .o_play_stop  (o_play_stop),
    .o_play_addr  (o_play_addr),
    .o_end_addr   (o_end_addr),
    .o_sram_sel   (o_sram_sel),
    .o_state      (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one clock; outputs are then sampled 1 ns after the edge
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop}
  function automatic logic [31:0] cmds();
    return {26'd0, o_rec_start, o_rec_pause, o_rec_stop, o_play_start, o_play_pause, o_play_stop};
  endfunction

  initial begin
    i_rst_n = 1'b1; i_key_rec = 0; i_key_play = 0; i_key_pause = 0; i_key_stop = 0;
    i_speed = 4'd1; i_fast = 0; i_rec_addr = '0; i_rec_full = 0; i_play_next = 0;
    repeat (3) step();
    i_rst_n = 1'b0;
    step();
    check("reset_state", 32'(o_state), 32'd0);
    check("reset_cmds", cmds(), 32'h00);
    check("reset_addr", 32'(o_play_addr), 32'd0);
    check("reset_end", 32'(o_end_addr), 32'd0);
    check("reset_sel", 32'(o_sram_sel), 32'd0);
    repeat (5) step();

    // ---- basic record then stop
    i_key_rec = 1; step(); i_key_rec = 0;
    check("rec_start_pulse", cmds(), 32'h20);
    check("rec_state", 32'(o_state), 32'd1);
    check("rec_sel", 32'(o_sram_sel), 32'd0);
    i_rec_addr = 20'h00123; step();
    check("rec_start_once", cmds(), 32'h00);
    check("rec_end_track", 32'(o_end_addr), 32'h123);
    i_key_stop = 1; step(); i_key_stop = 0;
    check("rec_stop_pulse", cmds(), 32'h08);
    check("rec_stop_state", 32'(o_state), 32'd0);
    check("rec_stop_end", 32'(o_end_addr), 32'h123);
    step();
    check("rec_stop_once", cmds(), 32'h00);

    // ---- empty recording, then play ignored
    i_rec_addr = '0;
    i_key_rec = 1; step(); i_key_rec = 0;
    i_key_stop = 1; step(); i_key_stop = 0;
    check("empty_end", 32'(o_end_addr), 32'd0);
    i_key_play = 1; step(); i_key_play = 0;
    check("play_empty_cmds", cmds(), 32'h00);
    check("play_empty_state", 32'(o_state), 32'd0);

    // ---- rec and play together: rec wins
    i_key_rec = 1; i_key_play = 1; step(); i_key_rec = 0; i_key_play = 0;
    check("recplay_cmds", cmds(), 32'h20);
    check("recplay_state", 32'(o_state), 32'd1);

    // ---- pause/resume recording keeps the length
    i_rec_addr = 20'h00010;
    i_key_pause = 1; step(); i_key_pause = 0;
    check("rec_pause_pulse", cmds(), 32'h10);
    check("rec_pause_state", 32'(o_state), 32'd2);
    check("rec_pause_end", 32'(o_end_addr), 32'h10);
    i_rec_addr = 20'h00055;
    i_key_play = 1; step(); i_key_play = 0;
    check("recp_play_ign", 32'(o_state), 32'd2);
    check("recp_end_hold", 32'(o_end_addr), 32'h10);
    i_key_rec = 1; step(); i_key_rec = 0;
    check("rec_resume_pulse", cmds(), 32'h20);
    check("rec_resume_end", 32'(o_end_addr), 32'h10);
    i_rec_addr = 20'h00010;
    i_key_stop = 1; step(); i_key_stop = 0;
    check("len16_end", 32'(o_end_addr), 32'h10);
    check("len16_state", 32'(o_state), 32'd0);

    // ---- fast play, speed 4, end 0x10
    i_fast = 1; i_speed = 4'd4;
    i_key_play = 1; step(); i_key_play = 0;
    check("fast_start_pulse", cmds(), 32'h04);
    check("fast_start_state", 32'(o_state), 32'd3);
    check("fast_start_sel", 32'(o_sram_sel), 32'd1);
    check("fast_start_addr", 32'(o_play_addr), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      i_play_next = 1; step(); i_play_next = 0;
      check("fast_addr", 32'(o_play_addr), 32'(4 * k));
      check("fast_state", 32'(o_state), 32'd3);
    end
    i_play_next = 1; step(); i_play_next = 0;
    check("fast_end_cmds", cmds(), 32'h01);
    check("fast_end_state", 32'(o_state), 32'd0);
    check("fast_end_addr", 32'(o_play_addr), 32'd16);
    check("fast_end_sel", 32'(o_sram_sel), 32'd0);

    // ---- slow play, speed 3, end 0x100
    i_rec_addr = 20'h00100;
    i_key_rec = 1; step(); i_key_rec = 0;
    i_key_stop = 1; step(); i_key_stop = 0;
    check("len256_end", 32'(o_end_addr), 32'h100);
    i_fast = 0; i_speed = 4'd3;
    i_key_play = 1; step(); i_key_play = 0;
    check("slow_start_state", 32'(o_state), 32'd3);
    begin
      logic [31:0] slow_exp [7] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2};
      for (int k = 0; k < 7; k++) begin
        i_play_next = 1; step(); i_play_next = 0;
        check("slow_addr", 32'(o_play_addr), slow_exp[k]);
      end
    end
    // speed 0 behaves as 1 (advance every pulse), slow then fast
    i_speed = 4'd0;
    i_play_next = 1; step(); i_play_next = 0;
    check("slow_speed0", 32'(o_play_addr), 32'd3);
    i_fast = 1;
    i_play_next = 1; step(); i_play_next = 0;
    check("fast_speed0", 32'(o_play_addr), 32'd4);
    // speed 15 saturates to 8
    i_speed = 4'd15;
    i_play_next = 1; step(); i_play_next = 0;
    check("fast_speed15", 32'(o_play_addr), 32'd12);

    // ---- play pause / resume / pause+stop
    i_key_pause = 1; step(); i_key_pause = 0;
    check("play_pause_pulse", cmds(), 32'h02);
    check("play_pause_state", 32'(o_state), 32'd4);
    check("play_pause_sel", 32'(o_sram_sel), 32'd1);
    i_play_next = 1; step(); i_play_next = 0;
    check("pause_next_ign", 32'(o_play_addr), 32'd12);
    i_key_play = 1; step(); i_key_play = 0;
    check("play_resume_pulse", cmds(), 32'h04);
    check("play_resume_state", 32'(o_state), 32'd3);
    check("play_resume_addr", 32'(o_play_addr), 32'd12);
    i_key_pause = 1; i_key_stop = 1; step(); i_key_pause = 0; i_key_stop = 0;
    check("pausestop_cmds", cmds(), 32'h01);
    check("pausestop_state", 32'(o_state), 32'd0);

    // ---- SRAM full ends the recording
    i_rec_addr = 20'hFFFFF;
    i_key_rec = 1; step(); i_key_rec = 0;
    i_rec_full = 1; step(); i_rec_full = 0;
    check("full_cmds", cmds(), 32'h08);
    check("full_state", 32'(o_state), 32'd0);
    check("full_end", 32'(o_end_addr), 32'hFFFFF);

    // ---- reset in the middle of playback
    i_key_play = 1; step(); i_key_play = 0;
    check("rst_play_state", 32'(o_state), 32'd3);
    i_play_next = 1; step(); i_play_next = 0;
    check("rst_play_addr", 32'(o_play_addr), 32'd8);
    i_rst_n = 1'b1; step();
    check("midrst_state", 32'(o_state), 32'd0);
    check("midrst_cmds", cmds(), 32'h00);
    check("midrst_addr", 32'(o_play_addr), 32'd0);
    check("midrst_end", 32'(o_end_addr), 32'd0);
    check("midrst_sel", 32'(o_sram_sel), 32'd0);
    i_rst_n = 1'b0; step();
    check("post_rst_cmds", cmds(), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aud_session_ctrl.md
Name: aud_session_ctrl

Overview:
- Top-level sequencer for the audio record/playback path.
- Turns debounced key pulses into one-cycle start/pause/stop commands for the I2S recorder and the player.
- Owns the recorded-length register, the playback address counter (with fast/slow speed stepping) and the SRAM owner select between recorder and player.
- Sits between the key/debounce logic and the recorder, player and SRAM mux.

Parameters:
ADDR_W, 20, SRAM word-address width
MAX_SPEED, 8, highest legal speed factor

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous reset, active-high (asserted when 1)
i_key_rec  in  1  one-cycle pulse: record / resume record
i_key_play  in  1  one-cycle pulse: play / resume play
i_key_pause  in  1  one-cycle pulse: pause current activity
i_key_stop  in  1  one-cycle pulse: stop current activity
i_speed  in  4  speed factor 1..MAX_SPEED
i_fast  in  1  1 = fast (skip samples), 0 = slow (repeat samples)
i_rec_addr  in  ADDR_W  recorder's current write address
i_rec_full  in  1  recorder reached the top of SRAM
i_play_next  in  1  one-cycle pulse: player consumed one sample
o_rec_start / o_rec_pause / o_rec_stop  out  1 each  one-cycle recorder commands
o_play_start / o_play_pause / o_play_stop  out  1 each  one-cycle player commands
o_play_addr  out  ADDR_W  SRAM read address for the player
o_end_addr  out  ADDR_W  last recorded address (recording length)
o_sram_sel  out  1  0 = recorder owns SRAM, 1 = player owns SRAM
o_state  out  3  FSM state encoding

Behaviour:
- States and encoding: IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4. Codes 5–7 are illegal and return to IDLE on the next cycle.
- Reset values: state IDLE; all command pulses 0; o_play_addr 0; o_end_addr 0; o_sram_sel 0; slow-repeat counter 0.
- Command latency: every output command pulse is registered.
  - It is high exactly one cycle, in the cycle after the causing key or event.
  - The state change happens on that same edge.
- Key priority within a single cycle: stop > pause > rec/play. If rec and play arrive together, rec wins in IDLE.
- IDLE:
  - key_rec -> REC. Pulse rec_start. o_end_addr cleared to 0.
  - key_play with o_end_addr != 0 -> PLAY. Pulse play_start. o_play_addr = 0, repeat counter = 0.
  - key_play with o_end_addr == 0 is ignored.
  - pause and stop keys are ignored.
- REC:
  - o_end_addr tracks i_rec_addr every cycle.
  - key_pause -> REC_PAUSE, pulse rec_pause.
  - key_stop or i_rec_full -> IDLE, pulse rec_stop. o_end_addr latches i_rec_addr on that edge.
  - key_play is ignored.
- REC_PAUSE:
  - key_rec -> REC, pulse rec_start. o_end_addr is kept, not cleared.
  - key_stop -> IDLE, pulse rec_stop.
  - key_play is ignored.
- PLAY:
  - key_pause -> PLAY_PAUSE, pulse play_pause.
  - key_stop -> IDLE, pulse play_stop.
  - End of recording: if an i_play_next step would take o_play_addr past o_end_addr, go to IDLE, pulse play_stop, and hold o_play_addr at its old value.
- PLAY_PAUSE:
  - key_play -> PLAY, pulse play_start, address kept.
  - key_stop -> IDLE, pulse play_stop.
  - i_play_next is ignored.
- Speed sanitising: i_speed 0 is treated as 1; values above MAX_SPEED saturate to MAX_SPEED. The value is sampled on every i_play_next.
- Address stepping (only in PLAY, on i_play_next):
  - Fast: o_play_addr += speed.
  - Slow: repeat counter increments. When it reaches speed-1, it resets to 0 and o_play_addr += 1.
  - Speed 1 advances by 1 per pulse in both modes.
- Address arithmetic is ADDR_W+1 bits wide for the end comparison. No wrap-around is permitted.
- o_sram_sel = 1 in PLAY and PLAY_PAUSE, 0 otherwise. It is registered with the state.
- Reset asserted mid-record or mid-play: IDLE next cycle; no stop pulse is emitted; o_end_addr is lost (set to 0).

Test Plan:
- Reset, then key_rec at cycle 10 -> o_rec_start high at cycle 11 only, o_state=1, o_sram_sel=0. Drive i_rec_addr=0x00123, then key_stop -> o_rec_stop one cycle, o_state=0, o_end_addr=0x00123.
- With o_end_addr=0, key_play -> no o_play_start, o_state stays 0. Then key_rec and key_play in the same cycle -> REC, rec_start only.
- Recording of length 0x00010, fast, speed=4: key_play, then 5 i_play_next pulses -> o_play_addr 0,4,8,12,16. The 5th pulse (would reach 20 > 16) -> play_stop, IDLE, addr held at 16.
- Slow, speed=3, end=0x00100: 7 i_play_next pulses -> o_play_addr = 2. i_speed=0 behaves as 1; i_speed=15 behaves as 8 in fast mode.
- PLAY: key_pause -> play_pause, state 4, i_play_next ignored (addr constant). key_play -> play_start, state 3. key_pause+key_stop in the same cycle -> play_stop, IDLE.
- REC: i_rec_full with i_rec_addr=0xFFFFF -> rec_stop, o_end_addr=0xFFFFF. Separately, assert i_rst_n mid-PLAY -> state 0, no stop pulse, all outputs at reset values.
